// File: rtl/alu_nbit_pkg.sv
// ---------------------------------------------------------------------------
// alu_nbit_pkg
// Shared constants for the n-bit ALU: the 3-bit opcode encodings for both
// operation classes and the values of the class select line.
// Arithmetic and logic opcodes reuse the same 3-bit codes; the class select
// decides which table a code belongs to.
// ---------------------------------------------------------------------------
package alu_nbit_pkg;

    typedef logic [2:0] opcode_t;

    // Operation class selected by the control input
    localparam logic CTRL_ARITH = 1'b0;
    localparam logic CTRL_LOGIC = 1'b1;

    // Arithmetic class opcodes
    localparam opcode_t OP_ADD   = 3'b000;
    localparam opcode_t OP_SUB   = 3'b001;
    localparam opcode_t OP_INCA  = 3'b010;
    localparam opcode_t OP_DECA  = 3'b011;
    localparam opcode_t OP_INCB  = 3'b100;
    localparam opcode_t OP_DECB  = 3'b101;
    localparam opcode_t OP_PASSA = 3'b110;
    localparam opcode_t OP_NEGA  = 3'b111;

    // Logic class opcodes
    localparam opcode_t OP_AND   = 3'b000;
    localparam opcode_t OP_OR    = 3'b001;
    localparam opcode_t OP_XOR   = 3'b010;
    localparam opcode_t OP_NAND  = 3'b011;
    localparam opcode_t OP_NOR   = 3'b100;
    localparam opcode_t OP_XNOR  = 3'b101;
    localparam opcode_t OP_NOTA  = 3'b110;
    localparam opcode_t OP_NOTB  = 3'b111;

endpackage

// File: rtl/alu_nbit_core.sv
// ---------------------------------------------------------------------------
// alu_nbit_core
// Purely combinational datapath of the n-bit ALU. Produces the value that the
// top-level register captures on the next rising clock edge.
//
// Ports:
//   a, b       [n-1:0]  unsigned operands
//   sel        [n-2:0]  operation select, only sel[2:0] is decoded
//   control             0 = arithmetic class, 1 = logic class
//   next_y     [n-1:0]  result to be registered
//   next_cout           carry / no-borrow flag to be registered
// ---------------------------------------------------------------------------
module alu_nbit_core
    import alu_nbit_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [n-2:0] sel,
    input  logic         control,
    output logic [n-1:0] next_y,
    output logic         next_cout
);

    // Zero-extended forms so every arithmetic op is a plain (n+1)-bit sum
    // whose top bit is the carry.
    localparam logic [n:0] ONE_EXT  = {{n{1'b0}}, 1'b1};
    localparam logic [n:0] ONES_EXT = {1'b0, {n{1'b1}}};

    opcode_t    op;
    logic [n:0] a_ext;
    logic [n:0] b_ext;
    logic [n:0] a_inv_ext;
    logic [n:0] b_inv_ext;
    logic [n:0] sum;

    assign op        = sel[2:0];
    assign a_ext     = {1'b0, a};
    assign b_ext     = {1'b0, b};
    assign a_inv_ext = {1'b0, ~a};
    assign b_inv_ext = {1'b0, ~b};

    // Select bits above bit 2 exist only for widths above 4 and carry no
    // meaning; they are folded into a deliberately unused signal.
    generate
        if (n > 4) begin : g_unused_sel
            logic unused_sel_bits;
            assign unused_sel_bits = ^sel[n-2:3];
        end
    endgenerate

    // Arithmetic ops: subtraction is a + ~b + 1 so cout reads as "no
    // borrow", decrement adds all-ones so cout drops only when the operand
    // is zero, and negation is ~a + 1 so cout is set only for a = 0.
    always_comb begin
        sum = '0;
        case (op)
            OP_ADD:   sum = a_ext + b_ext;
            OP_SUB:   sum = a_ext + b_inv_ext + ONE_EXT;
            OP_INCA:  sum = a_ext + ONE_EXT;
            OP_DECA:  sum = a_ext + ONES_EXT;
            OP_INCB:  sum = b_ext + ONE_EXT;
            OP_DECB:  sum = b_ext + ONES_EXT;
            OP_PASSA: sum = a_ext;
            OP_NEGA:  sum = a_inv_ext + ONE_EXT;
            default:  sum = '0;
        endcase
    end

    // Class mux: arithmetic takes the sum and its carry, logic ops never
    // report a carry. Defaults keep undefined encodings at zero.
    always_comb begin
        next_y    = '0;
        next_cout = 1'b0;
        if (control == CTRL_ARITH) begin
            next_y    = sum[n-1:0];
            next_cout = sum[n];
        end else begin
            case (op)
                OP_AND:  next_y = a & b;
                OP_OR:   next_y = a | b;
                OP_XOR:  next_y = a ^ b;
                OP_NAND: next_y = ~(a & b);
                OP_NOR:  next_y = ~(a | b);
                OP_XNOR: next_y = ~(a ^ b);
                OP_NOTA: next_y = ~a;
                OP_NOTB: next_y = ~b;
                default: next_y = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_nbit.sv
// ---------------------------------------------------------------------------
// alu_nbit
// Parameterised n-bit ALU with a registered result: operands and select are
// sampled on a rising clk edge and the result appears after that edge. A new
// operation is accepted every cycle.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low clear of y and cout
//   a, b       [n-1:0]  unsigned operands
//   sel        [n-2:0]  operation select, only sel[2:0] is decoded
//   control             0 = arithmetic class, 1 = logic class
//   y          [n-1:0]  registered result
//   cout                registered carry / no-borrow flag
// ---------------------------------------------------------------------------
module alu_nbit
    import alu_nbit_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [n-2:0] sel,
    input  logic         control,
    output logic [n-1:0] y,
    output logic         cout
);

    logic [n-1:0] next_y;
    logic         next_cout;

    alu_nbit_core #(
        .n (n)
    ) u_core (
        .a         (a),
        .b         (b),
        .sel       (sel),
        .control   (control),
        .next_y    (next_y),
        .next_cout (next_cout)
    );

    // Output register; reset clears it immediately and drops whatever
    // operation was about to be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y    <= '0;
            cout <= 1'b0;
        end else begin
            y    <= next_y;
            cout <= next_cout;
        end
    end

endmodule

// File: tb/tb_alu_nbit.sv
// ---------------------------------------------------------------------------
// tb_alu_nbit
// Directed and random checks of the 4-bit ALU. Expected {cout, y} values are
// queued when an operation is driven and popped once the register has
// captured it one edge later.
// ---------------------------------------------------------------------------
module tb_alu_nbit;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-2:0] sel;
    logic         control;
    logic [N-1:0] y;
    logic         cout;

    int checks = 0;
    int errors = 0;

    logic [N:0] expected_q[$];

    alu_nbit #(
        .n (N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .sel     (sel),
        .control (control),
        .y       (y),
        .cout    (cout)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a broken run still ends with a report
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Independent reference model for a 4-bit ALU, returns {cout, y}
    function automatic logic [N:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic mctrl, input logic [2:0] msel);
        int s;
        int ia;
        int ib;
        logic [N-1:0] r;
        ia = int'(ma);
        ib = int'(mb);
        s  = 0;
        r  = '0;
        if (mctrl == 1'b0) begin
            case (msel)
                3'd0: s = ia + ib;
                3'd1: s = ia + (15 - ib) + 1;
                3'd2: s = ia + 1;
                3'd3: s = ia + 15;
                3'd4: s = ib + 1;
                3'd5: s = ib + 15;
                3'd6: s = ia;
                default: s = (15 - ia) + 1;
            endcase
            return {(s >= 16) ? 1'b1 : 1'b0, 4'(s % 16)};
        end
        case (msel)
            3'd0: r = ma & mb;
            3'd1: r = ma | mb;
            3'd2: r = ma ^ mb;
            3'd3: r = ~(ma & mb);
            3'd4: r = ~(ma | mb);
            3'd5: r = ~(ma ^ mb);
            3'd6: r = ~ma;
            default: r = ~mb;
        endcase
        return {1'b0, r};
    endfunction

    // Drive one operation between edges and queue its expected result
    task automatic apply_stimulus(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                  input logic tctrl, input logic [2:0] tsel,
                                  input logic [N:0] texp);
        @(negedge clk);
        a       = ta;
        b       = tb;
        control = tctrl;
        sel     = tsel;
        expected_q.push_back(texp);
    endtask

    // Let the register capture the operation, then compare against the queue
    task automatic check_output(input string tag);
        logic [N:0] exp_v;
        @(posedge clk);
        #1;
        checks++;
        if (expected_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s observed empty-queue expected queued result", tag);
        end else begin
            exp_v = expected_q.pop_front();
            assert ({cout, y} === exp_v) else begin
                errors++;
                $error("[TB] FAIL %s observed cout=%b y=%b expected cout=%b y=%b",
                       tag, cout, y, exp_v[N], exp_v[N-1:0]);
            end
        end
    endtask

    // Direct comparison of the outputs against a constant, no clock edge
    task automatic check_now(input string tag, input logic [N:0] exp_v);
        checks++;
        assert ({cout, y} === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed cout=%b y=%b expected cout=%b y=%b",
                   tag, cout, y, exp_v[N], exp_v[N-1:0]);
        end
    endtask

    // Directed sequence followed by back-to-back random operations
    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        logic [2:0]   rs;

        rst_n   = 1'b0;
        a       = '0;
        b       = '0;
        sel     = '0;
        control = 1'b0;
        #7;
        check_now("reset_initial", 5'b0_0000);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(4'b1110, 4'b1001, 1'b0, 3'b000, 5'b1_0111);
        check_output("add_carry");

        // Asynchronous clear between edges, then hold until the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check_now("reset_async", 5'b0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_now("reset_hold", 5'b0_0000);

        apply_stimulus(4'b0011, 4'b0100, 1'b0, 3'b000, 5'b0_0111);
        check_output("add_nocarry");
        apply_stimulus(4'b0101, 4'b0111, 1'b0, 3'b001, 5'b0_1110);
        check_output("sub_borrow");
        apply_stimulus(4'b0111, 4'b0111, 1'b0, 3'b001, 5'b1_0000);
        check_output("sub_equal");
        apply_stimulus(4'b1111, 4'b0000, 1'b0, 3'b010, 5'b1_0000);
        check_output("inca_wrap");
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 3'b011, 5'b0_1111);
        check_output("deca_zero");
        apply_stimulus(4'b0000, 4'b0011, 1'b0, 3'b111, 5'b1_0000);
        check_output("nega_zero");
        apply_stimulus(4'b0001, 4'b0011, 1'b0, 3'b111, 5'b0_1111);
        check_output("nega_one");
        apply_stimulus(4'b0110, 4'b1111, 1'b0, 3'b100, 5'b1_0000);
        check_output("incb_wrap");
        apply_stimulus(4'b0110, 4'b0000, 1'b0, 3'b101, 5'b0_1111);
        check_output("decb_zero");
        apply_stimulus(4'b1010, 4'b0101, 1'b0, 3'b110, 5'b0_1010);
        check_output("passa");

        apply_stimulus(4'b1100, 4'b1010, 1'b1, 3'b000, 5'b0_1000);
        check_output("and");
        apply_stimulus(4'b1100, 4'b1010, 1'b1, 3'b001, 5'b0_1110);
        check_output("or");
        apply_stimulus(4'b1100, 4'b1010, 1'b1, 3'b010, 5'b0_0110);
        check_output("xor");
        apply_stimulus(4'b1100, 4'b1010, 1'b1, 3'b011, 5'b0_0111);
        check_output("nand");
        apply_stimulus(4'b1100, 4'b1010, 1'b1, 3'b100, 5'b0_0001);
        check_output("nor");
        apply_stimulus(4'b1100, 4'b1010, 1'b1, 3'b101, 5'b0_1001);
        check_output("xnor");
        apply_stimulus(4'b1100, 4'b1010, 1'b1, 3'b110, 5'b0_0011);
        check_output("nota");
        apply_stimulus(4'b1100, 4'b1010, 1'b1, 3'b111, 5'b0_0101);
        check_output("notb");

        // New operands every cycle; each edge must deliver the previous op
        for (int i = 0; i < 16; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            rs = 3'($urandom_range(0, 7));
            apply_stimulus(ra, rb, rc, rs, model(ra, rb, rc, rs));
            check_output("random");
        end

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
